// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-context register file.
package regfile_pkg;

  // Init sequencer states: CLEAR zeroes the array, READY services the ports.
  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // $clog2 that never returns 0, so a single-entry dimension still gets a 1-bit field.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter.sv
// Bypass selector for one read port: finds the highest-index write port that
// targets the same entry this cycle and returns its data.
module regfile_wr_arbiter #(
  parameter int EW        = 7,
  parameter int REG_WIDTH = 32,
  parameter int WR_PORTS  = 2
) (
  input  logic [EW-1:0]                       rd_entry,
  input  logic [WR_PORTS-1:0]                 wr_en,
  input  logic [WR_PORTS-1:0][EW-1:0]         wr_entry,
  input  logic [WR_PORTS-1:0][REG_WIDTH-1:0]  wr_data,
  output logic                                hit,
  output logic [REG_WIDTH-1:0]                data
);

  // Ascending scan so a later (higher-index) match overrides an earlier one.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves one unassigned would infer a latch.
    hit  = 1'b0;
    data = '0;
    for (int w = 0; w < WR_PORTS; w++) begin
      if (wr_en[w] && (wr_entry[w] == rd_entry)) begin
        hit  = 1'b1;
        data = wr_data[w];
      end
    end
  end

endmodule

// File: rtl/multiport_register_file.sv
// Multi-context, multi-port register file with write-first bypass and a
// self-clearing init sequencer.
// Optional feature: define REGFILE_R0_ZERO_EN to hardwire register 0 of every
// context to zero (reads return 0, writes to addr 0 are discarded).
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter  int REG_COUNT = 32,
  parameter  int REG_WIDTH = 32,
  parameter  int CTX_COUNT = 4,
  parameter  int RD_PORTS  = 3,
  parameter  int WR_PORTS  = 2,
  localparam int AW        = $clog2(REG_COUNT),
  localparam int CW        = clog2_min1(CTX_COUNT),
  localparam int DEPTH     = REG_COUNT * CTX_COUNT,
  localparam int EW        = AW + CW
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               clear_i,
  output logic                               init_done_o,
  input  logic [RD_PORTS-1:0]                rd_en_i,
  input  logic [RD_PORTS-1:0][CW-1:0]        rd_ctx_i,
  input  logic [RD_PORTS-1:0][AW-1:0]        rd_addr_i,
  output logic [RD_PORTS-1:0][REG_WIDTH-1:0] rd_data_o,
  output logic [RD_PORTS-1:0]                rd_valid_o,
  input  logic [WR_PORTS-1:0]                wr_en_i,
  input  logic [WR_PORTS-1:0][CW-1:0]        wr_ctx_i,
  input  logic [WR_PORTS-1:0][AW-1:0]        wr_addr_i,
  input  logic [WR_PORTS-1:0][REG_WIDTH-1:0] wr_data_i
);

  logic [REG_WIDTH-1:0] mem [DEPTH];

  rf_state_e state;
  logic [EW-1:0] clr_cnt;

  logic [WR_PORTS-1:0]                wr_act;
  logic [WR_PORTS-1:0][EW-1:0]        wr_entry;
  logic [RD_PORTS-1:0][EW-1:0]        rd_entry;
  logic [RD_PORTS-1:0]                byp_hit;
  logic [RD_PORTS-1:0][REG_WIDTH-1:0] byp_data;
  logic [RD_PORTS-1:0][REG_WIDTH-1:0] rd_word;

  // Qualify writes: only in READY, and never to a hardwired register 0.
  always_comb begin
    wr_act   = '0;
    wr_entry = '0;
    for (int w = 0; w < WR_PORTS; w++) begin
      wr_entry[w] = {wr_ctx_i[w], wr_addr_i[w]};
      wr_act[w]   = wr_en_i[w] && (state == RF_READY);
`ifdef REGFILE_R0_ZERO_EN
      if (wr_addr_i[w] == '0) wr_act[w] = 1'b0;
`endif
    end
  end

  // One bypass selector per read port, using the qualified write enables.
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_byp
    assign rd_entry[p] = {rd_ctx_i[p], rd_addr_i[p]};

    regfile_wr_arbiter #(
      .EW       (EW),
      .REG_WIDTH(REG_WIDTH),
      .WR_PORTS (WR_PORTS)
    ) u_arb (
      .rd_entry(rd_entry[p]),
      .wr_en   (wr_act),
      .wr_entry(wr_entry),
      .wr_data (wr_data_i),
      .hit     (byp_hit[p]),
      .data    (byp_data[p])
    );
  end

  // Write-first read word: in-flight write data beats the stored value.
  always_comb begin
    rd_word = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_word[p] = byp_hit[p] ? byp_data[p] : mem[rd_entry[p]];
`ifdef REGFILE_R0_ZERO_EN
      if (rd_addr_i[p] == '0) rd_word[p] = '0;
`endif
    end
  end

  // Init sequencer: walk every entry once, then serve ports until clear_i.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= RF_CLEAR;
      clr_cnt     <= '0;
      init_done_o <= 1'b0;
    end else begin
      case (state)
        RF_CLEAR: begin
          if (clr_cnt == EW'(DEPTH - 1)) begin
            state       <= RF_READY;
            init_done_o <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + EW'(1);
          end
        end
        RF_READY: begin
          if (clear_i) begin
            state       <= RF_CLEAR;
            clr_cnt     <= '0;
            init_done_o <= 1'b0;
          end
        end
        default: begin
          state   <= RF_CLEAR;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  // Array update: sequencer zeroing in CLEAR, user writes in READY.
  // NOTE: the array has no reset branch on purpose; the sequencer zeroes it, and a reset here would turn RAM into flops.
  always_ff @(posedge clk_i) begin
    if (state == RF_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      // NOTE: non-blocking updates in ascending port order, so the last (highest-index) write to an entry wins.
      for (int w = 0; w < WR_PORTS; w++) begin
        if (wr_act[w]) mem[wr_entry[w]] <= wr_data_i[w];
      end
    end
  end

  // Registered read ports: capture on request in READY, otherwise hold data.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_data_o  <= '0;
      rd_valid_o <= '0;
    end else begin
      for (int p = 0; p < RD_PORTS; p++) begin
        if ((state == RF_READY) && rd_en_i[p]) begin
          rd_data_o[p]  <= rd_word[p];
          rd_valid_o[p] <= 1'b1;
        end else begin
          rd_valid_o[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file: table of single-cycle vectors
// plus hand-written sequences for init, clear and mid-clear reset.
module tb_multiport_register_file;

`ifdef REGFILE_R0_ZERO_EN
  localparam logic [31:0] R0_EXP = 32'h0;
`else
  localparam logic [31:0] R0_EXP = 32'h0000_FFFF;
`endif

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              clear_i;
  logic              init_done_o;
  logic [2:0]        rd_en_i;
  logic [2:0][1:0]   rd_ctx_i;
  logic [2:0][4:0]   rd_addr_i;
  logic [2:0][31:0]  rd_data_o;
  logic [2:0]        rd_valid_o;
  logic [1:0]        wr_en_i;
  logic [1:0][1:0]   wr_ctx_i;
  logic [1:0][4:0]   wr_addr_i;
  logic [1:0][31:0]  wr_data_i;

  multiport_register_file dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (clear_i),
    .init_done_o(init_done_o),
    .rd_en_i    (rd_en_i),
    .rd_ctx_i   (rd_ctx_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .wr_en_i    (wr_en_i),
    .wr_ctx_i   (wr_ctx_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]       wr_en;
    logic [1:0][1:0]  wr_ctx;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic [2:0]       rd_en;
    logic [2:0][1:0]  rd_ctx;
    logic [2:0][4:0]  rd_addr;
    logic [2:0]       exp_valid;
    logic [2:0][31:0] exp_data;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic vnew(input int i);
    vecs[i].wr_en     = '0;
    vecs[i].wr_ctx    = '0;
    vecs[i].wr_addr   = '0;
    vecs[i].wr_data   = '0;
    vecs[i].rd_en     = '0;
    vecs[i].rd_ctx    = '0;
    vecs[i].rd_addr   = '0;
    vecs[i].exp_valid = '0;
    vecs[i].exp_data  = '0;
  endtask

  task automatic vwr(input int i, input int p, input logic [1:0] c, input logic [4:0] a,
                     input logic [31:0] d);
    vecs[i].wr_en[p]   = 1'b1;
    vecs[i].wr_ctx[p]  = c;
    vecs[i].wr_addr[p] = a;
    vecs[i].wr_data[p] = d;
  endtask

  task automatic vrd(input int i, input int p, input logic [1:0] c, input logic [4:0] a);
    vecs[i].rd_en[p]   = 1'b1;
    vecs[i].rd_ctx[p]  = c;
    vecs[i].rd_addr[p] = a;
  endtask

  task automatic vexp(input int i, input logic [2:0] v, input logic [31:0] d0,
                      input logic [31:0] d1, input logic [31:0] d2);
    vecs[i].exp_valid   = v;
    vecs[i].exp_data[0] = d0;
    vecs[i].exp_data[1] = d1;
    vecs[i].exp_data[2] = d2;
  endtask

  task automatic drive_idle();
    clear_i   = 1'b0;
    rd_en_i   = '0;
    rd_ctx_i  = '0;
    rd_addr_i = '0;
    wr_en_i   = '0;
    wr_ctx_i  = '0;
    wr_addr_i = '0;
    wr_data_i = '0;
  endtask

  // Counts rising edges until init_done_o is seen high; bounded at 300.
  task automatic wait_init(output int n);
    n = 0;
    while (n < 300) begin
      @(posedge clk_i);
      #1;
      n++;
      if (init_done_o) break;
    end
  endtask

  int n;

  initial begin
    // Vector table; data columns include values held from earlier reads.
    vnew(0);  vrd(0, 0, 2'd3, 5'd31);                  vexp(0, 3'b001, 0, 0, 0);
    vnew(1);  vwr(1, 0, 2'd1, 5'd5, 32'hDEAD_BEEF);    vexp(1, 3'b000, 0, 0, 0);
    vnew(2);                                           vexp(2, 3'b000, 0, 0, 0);
    vnew(3);  vrd(3, 0, 2'd1, 5'd5); vrd(3, 1, 2'd1, 5'd5); vrd(3, 2, 2'd1, 5'd5);
              vexp(3, 3'b111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    vnew(4);  vrd(4, 1, 2'd0, 5'd5);
              vexp(4, 3'b010, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
    vnew(5);  vwr(5, 0, 2'd2, 5'd7, 32'h11); vwr(5, 1, 2'd2, 5'd7, 32'h22);
              vexp(5, 3'b000, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
    vnew(6);  vrd(6, 2, 2'd2, 5'd7);
              vexp(6, 3'b100, 32'hDEAD_BEEF, 0, 32'h22);
    vnew(7);  vwr(7, 0, 2'd0, 5'd9, 32'hA5A5); vrd(7, 0, 2'd0, 5'd9);
              vexp(7, 3'b001, 32'hA5A5, 0, 32'h22);
    vnew(8);  vwr(8, 0, 2'd3, 5'd1, 32'h1); vwr(8, 1, 2'd3, 5'd1, 32'h2); vrd(8, 1, 2'd3, 5'd1);
              vexp(8, 3'b010, 32'hA5A5, 32'h2, 32'h22);
    vnew(9);  vrd(9, 0, 2'd3, 5'd1); vrd(9, 2, 2'd0, 5'd9);
              vexp(9, 3'b101, 32'h2, 32'h2, 32'hA5A5);
    vnew(10); vwr(10, 1, 2'd0, 5'd0, 32'hFFFF); vrd(10, 0, 2'd0, 5'd0);
              vexp(10, 3'b001, R0_EXP, 32'h2, 32'hA5A5);
    vnew(11); vrd(11, 1, 2'd0, 5'd0);
              vexp(11, 3'b010, R0_EXP, R0_EXP, 32'hA5A5);
    vnew(12); vwr(12, 1, 2'd1, 5'd3, 32'h33);
              vexp(12, 3'b000, R0_EXP, R0_EXP, 32'hA5A5);
    vnew(13); vrd(13, 0, 2'd1, 5'd3);
              vexp(13, 3'b001, 32'h33, R0_EXP, 32'hA5A5);

    // Reset state, then init latency.
    drive_idle();
    reset_i = 1'b1;
    #12;
    check("reset_init_done", {31'b0, init_done_o}, 32'h0);
    check("reset_rd_valid", {29'b0, rd_valid_o}, 32'h0);
    check("reset_rd_data0", rd_data_o[0], 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    wait_init(n);
    check("init_latency", n, 128);

    // Table-driven single-cycle vectors.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      rd_en_i   = vecs[i].rd_en;
      rd_ctx_i  = vecs[i].rd_ctx;
      rd_addr_i = vecs[i].rd_addr;
      wr_en_i   = vecs[i].wr_en;
      wr_ctx_i  = vecs[i].wr_ctx;
      wr_addr_i = vecs[i].wr_addr;
      wr_data_i = vecs[i].wr_data;
      @(posedge clk_i);
      #1;
      check($sformatf("v%0d_valid", i), {29'b0, rd_valid_o}, {29'b0, vecs[i].exp_valid});
      for (int p = 0; p < 3; p++)
        check($sformatf("v%0d_p%0d_data", i, p), rd_data_o[p], vecs[i].exp_data[p]);
    end

    // Clear pulse: init_done drops, write late in CLEAR is lost, clear_i ignored.
    @(negedge clk_i);
    drive_idle();
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("clear_drop", {31'b0, init_done_o}, 32'h0);
    n = 0;
    while (n < 300) begin
      @(negedge clk_i);
      drive_idle();
      if (n == 99) begin
        clear_i      = 1'b1;
        wr_en_i[0]   = 1'b1;
        wr_ctx_i[0]  = 2'd0;
        wr_addr_i[0] = 5'd3;
        wr_data_i[0] = 32'h77;
        rd_en_i[0]   = 1'b1;
        rd_ctx_i[0]  = 2'd1;
        rd_addr_i[0] = 5'd3;
      end
      @(posedge clk_i);
      #1;
      n++;
      if (n == 100) begin
        check("clear_rd_valid", {29'b0, rd_valid_o}, 32'h0);
        check("clear_rd_hold", rd_data_o[0], 32'h33);
      end
      if (init_done_o) break;
    end
    check("clear_latency", n, 128);

    // After clear: dropped write and earlier data both read as zero.
    @(negedge clk_i);
    drive_idle();
    rd_en_i      = 3'b011;
    rd_ctx_i[0]  = 2'd0;
    rd_addr_i[0] = 5'd3;
    rd_ctx_i[1]  = 2'd0;
    rd_addr_i[1] = 5'd9;
    @(posedge clk_i);
    #1;
    check("post_clear_valid", {29'b0, rd_valid_o}, 32'h3);
    check("post_clear_lost_wr", rd_data_o[0], 32'h0);
    check("post_clear_r9", rd_data_o[1], 32'h0);

    // Reset at clear cycle 50 restarts the full count.
    @(negedge clk_i);
    drive_idle();
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    repeat (50) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    check("midclear_rst_done", {31'b0, init_done_o}, 32'h0);
    check("midclear_rst_data2", rd_data_o[2], 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    wait_init(n);
    check("midclear_rst_latency", n, 128);

    @(negedge clk_i);
    drive_idle();
    rd_en_i[2]   = 1'b1;
    rd_ctx_i[2]  = 2'd1;
    rd_addr_i[2] = 5'd5;
    @(posedge clk_i);
    #1;
    check("final_valid", {29'b0, rd_valid_o}, 32'h4);
    check("final_r5_zero", rd_data_o[2], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
